mtimer_irq_gen: RTL and testbench

// Memory-mapped machine timer (mtime/mtimecmp) that sources the timer interrupt consumed by the CSR unit.

---
 rtl/mtimer_irq_gen_if.sv | 21 ++
 rtl/mtimer_irq_gen.sv | 143 ++++++++++++++
 tb/tb_mtimer_irq_gen.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mtimer_irq_gen_if.sv
// rtl/mtimer_irq_gen_if.sv - data-memory bus port of the machine timer
interface mtimer_irq_gen_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        sel_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, wstrb_i,
    input  rdata_o, ack_o, sel_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, wstrb_i,
    output rdata_o, ack_o, sel_o
  );
endinterface

// File: rtl/mtimer_irq_gen.sv
// rtl/mtimer_irq_gen.sv - memory-mapped mtime/mtimecmp machine timer with level interrupt
module mtimer_irq_gen #(
  parameter int unsigned PRESCALE  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800
) (
  input  logic            clk,
  input  logic            rst,
  mtimer_irq_gen_if.slave bus,
  output logic            timer_irq
);

  localparam logic [15:0] PRESC_LAST    = 16'(PRESCALE - 1);
  localparam logic [2:0]  OFF_MTIME_LO  = 3'd0;
  localparam logic [2:0]  OFF_MTIME_HI  = 3'd1;
  localparam logic [2:0]  OFF_MCMP_LO   = 3'd2;
  localparam logic [2:0]  OFF_MCMP_HI   = 3'd3;
  localparam logic [2:0]  OFF_CTRL      = 3'd4;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] mtime_inc;
  logic [63:0] mtime_nxt;
  logic [63:0] mtimecmp_nxt;
  logic [31:0] hi_shadow;
  logic [31:0] rd_mux;
  logic [15:0] prescaler;
  logic        cnt_en;
  logic        tick;
  logic        hit;
  logic        acc_wr;
  logic        acc_rd;
  logic [2:0]  offset;
  logic        addr_unused;

  // Byte-lane merge: lanes enabled in strb take the bus data, the rest keep cur.
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = strb[i] ? data[8*i +: 8] : cur[8*i +: 8];
    end
    return merged;
  endfunction

  // Word-aligned decode: the byte offset within a word is irrelevant.
  assign addr_unused = ^bus.addr_i[1:0];
  assign hit         = (bus.addr_i[31:5] == BASE_ADDR[31:5]);
  assign bus.sel_o   = hit;
  assign offset      = bus.addr_i[4:2];
  assign acc_wr      = bus.req_i & hit & bus.we_i;
  assign acc_rd      = bus.req_i & hit & ~bus.we_i;

  assign tick        = cnt_en && (prescaler == PRESC_LAST);
  assign mtime_inc   = mtime + 64'(tick);

  // Next mtime: the ticked value, with a written half overriding only its own lanes so the carry still reaches the other half.
  always_comb begin
    mtime_nxt = mtime_inc;
    if (acc_wr && offset == OFF_MTIME_LO) begin
      mtime_nxt[31:0] = merge_bytes(mtime_inc[31:0], bus.wdata_i, bus.wstrb_i);
    end else if (acc_wr && offset == OFF_MTIME_HI) begin
      mtime_nxt[63:32] = merge_bytes(mtime_inc[63:32], bus.wdata_i, bus.wstrb_i);
    end
  end

  // Next mtimecmp: byte-lane writes to either half.
  always_comb begin
    mtimecmp_nxt = mtimecmp;
    if (acc_wr && offset == OFF_MCMP_LO) begin
      mtimecmp_nxt[31:0] = merge_bytes(mtimecmp[31:0], bus.wdata_i, bus.wstrb_i);
    end else if (acc_wr && offset == OFF_MCMP_HI) begin
      mtimecmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], bus.wdata_i, bus.wstrb_i);
    end
  end

  // Read mux; MTIME_HI returns the value latched by the last MTIME_LO read so a LO/HI pair is coherent.
  always_comb begin
    rd_mux = 32'd0;
    case (offset)
      OFF_MTIME_LO: rd_mux = mtime[31:0];
      OFF_MTIME_HI: rd_mux = hi_shadow;
      OFF_MCMP_LO:  rd_mux = mtimecmp[31:0];
      OFF_MCMP_HI:  rd_mux = mtimecmp[63:32];
      OFF_CTRL:     rd_mux = {31'd0, cnt_en};
      default:      rd_mux = 32'd0;
    endcase
  end

  // Prescaler: wraps at PRESCALE-1 while counting, frozen while CNT_EN is clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= 16'd0;
    end else if (cnt_en) begin
      prescaler <= tick ? 16'd0 : prescaler + 16'd1;
    end
  end

  // Timer registers and counter enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime    <= 64'd0;
      mtimecmp <= '1;
      cnt_en   <= 1'b1;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      if (acc_wr && offset == OFF_CTRL && bus.wstrb_i[0]) begin
        cnt_en <= bus.wdata_i[0];
      end
    end
  end

  // High-half snapshot taken whenever software reads MTIME_LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_shadow <= 32'd0;
    end else if (acc_rd && offset == OFF_MTIME_LO) begin
      hi_shadow <= mtime[63:32];
    end
  end

  // Bus response one cycle after every accepted request; no stall path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ack_o   <= 1'b0;
      bus.rdata_o <= 32'd0;
    end else begin
      bus.ack_o   <= bus.req_i & hit;
      bus.rdata_o <= acc_rd ? rd_mux : 32'd0;
    end
  end

  // Level interrupt from the current compare; not gated by CNT_EN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_mtimer_irq_gen.sv
// tb/tb_mtimer_irq_gen.sv - self-checking bench for mtimer_irq_gen
module tb_mtimer_irq_gen;
  localparam logic [31:0] BASE = 32'h0000_0800;
  localparam int PRE[2] = '{4, 1};

  logic clk = 1'b0;
  logic rst;
  logic irq_a, irq_b;

  mtimer_irq_gen_if bus_a ();
  mtimer_irq_gen_if bus_b ();

  mtimer_irq_gen #(.PRESCALE(4), .BASE_ADDR(BASE)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .timer_irq(irq_a));
  mtimer_irq_gen #(.PRESCALE(1), .BASE_ADDR(BASE)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .timer_irq(irq_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state, index 0 = dut_a, 1 = dut_b
  logic [63:0] m_mt[2];
  logic [63:0] m_cmp[2];
  int          m_pre[2];
  logic [31:0] m_sh[2];
  logic [31:0] m_rd[2];
  bit          m_irq[2];
  bit          m_en, m_ack, m_rdv;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : cur[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mt[k] = 64'd0; m_cmp[k] = '1; m_pre[k] = 0;
      m_sh[k] = 32'd0; m_rd[k] = 32'd0; m_irq[k] = 1'b0;
    end
    m_en = 1'b1; m_ack = 1'b0; m_rdv = 1'b0;
  endtask

  task automatic drive(input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st);
    bus_a.req_i = req; bus_a.we_i = we; bus_a.addr_i = addr; bus_a.wdata_i = wd; bus_a.wstrb_i = st;
    bus_b.req_i = req; bus_b.we_i = we; bus_b.addr_i = addr; bus_b.wdata_i = wd; bus_b.wstrb_i = st;
  endtask

  // One bus cycle: called at posedge+1, returns at the next posedge+1 after checking outputs.
  task automatic step(input bit req, input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] st);
    bit hit, acc, tick;
    logic [2:0] off;
    logic [63:0] nmt;
    drive(req, we, addr, wd, st);
    #1;
    hit = (addr[31:5] == BASE[31:5]);
    off = addr[4:2];
    acc = req && hit;
    check("sel_a", bus_a.sel_o, hit);
    check("sel_b", bus_b.sel_o, hit);
    for (int k = 0; k < 2; k++) begin
      tick = m_en && (m_pre[k] == PRE[k] - 1);
      m_irq[k] = (m_mt[k] >= m_cmp[k]);
      case (off)
        3'd0: m_rd[k] = m_mt[k][31:0];
        3'd1: m_rd[k] = m_sh[k];
        3'd2: m_rd[k] = m_cmp[k][31:0];
        3'd3: m_rd[k] = m_cmp[k][63:32];
        3'd4: m_rd[k] = {31'd0, m_en};
        default: m_rd[k] = 32'd0;
      endcase
      nmt = m_mt[k] + (tick ? 64'd1 : 64'd0);
      if (acc && we) begin
        if (off == 3'd0) nmt[31:0]  = lanes(nmt[31:0], wd, st);
        if (off == 3'd1) nmt[63:32] = lanes(nmt[63:32], wd, st);
        if (off == 3'd2) m_cmp[k][31:0]  = lanes(m_cmp[k][31:0], wd, st);
        if (off == 3'd3) m_cmp[k][63:32] = lanes(m_cmp[k][63:32], wd, st);
      end
      if (acc && !we && off == 3'd0) m_sh[k] = m_mt[k][63:32];
      if (m_en) m_pre[k] = tick ? 0 : m_pre[k] + 1;
      m_mt[k] = nmt;
    end
    if (acc && we && off == 3'd4 && st[0]) m_en = wd[0];
    m_ack = acc;
    m_rdv = acc && !we;
    @(posedge clk);
    #1;
    check("ack_a", bus_a.ack_o, m_ack);
    check("ack_b", bus_b.ack_o, m_ack);
    check("irq_a", irq_a, m_irq[0]);
    check("irq_b", irq_b, m_irq[1]);
    if (m_rdv) begin
      check("rdata_a", bus_a.rdata_o, m_rd[0]);
      check("rdata_b", bus_b.rdata_o, m_rd[1]);
    end
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    step(1'b1, 1'b1, BASE + 32'(off * 4), d, 4'hF);
  endtask

  task automatic rd(input int off);
    step(1'b1, 1'b0, BASE + 32'(off * 4), 32'd0, 4'h0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    logic [31:0] lo_val;
    rst = 1'b1;
    do_reset();

    // reset state
    check("rst_ack", bus_a.ack_o, 1'b0);
    check("rst_irq", irq_a, 1'b0);
    check("rst_rdata", bus_a.rdata_o, 32'd0);

    // T2 tick rate and freeze
    repeat (39) idle();
    rd(0);
    check("t2_rate", (bus_a.rdata_o >= 32'd9 && bus_a.rdata_o <= 32'd11), 1'b1);
    wr(4, 32'd0);
    repeat (20) idle();
    rd(0);
    check("t2_frozen", bus_a.rdata_o, 32'd10);

    // T3 compare rise and fall
    wr(2, 32'd5);
    wr(3, 32'd0);
    wr(0, 32'd0);
    wr(1, 32'd0);
    wr(4, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle();
      if (m_mt[0] == 64'd5) found = 1'b1;
    end
    if (!found) check("t3_timeout", 1'b0, 1'b1);
    check("t3_irq_low", irq_a, 1'b0);
    idle();
    check("t3_irq_rise", irq_a, 1'b1);
    wr(2, 32'd100);
    check("t3_irq_hold", irq_a, 1'b1);
    idle();
    check("t3_irq_fall", irq_a, 1'b0);

    // T1 reset mid-operation with a pending ack and a raised irq
    wr(2, 32'd0);
    idle();
    check("t1_irq_pre", irq_a, 1'b1);
    rd(0);
    rst = 1'b1;
    #1;
    check("t1_ack_a", bus_a.ack_o, 1'b0);
    check("t1_ack_b", bus_b.ack_o, 1'b0);
    check("t1_irq_a", irq_a, 1'b0);
    do_reset();
    rd(0);
    check("t1_lo_a", bus_a.rdata_o, 32'd0);
    check("t1_lo_b", bus_b.rdata_o, 32'd0);
    rd(3);
    check("t1_cmphi", bus_a.rdata_o, 32'hFFFF_FFFF);

    // T4 carry coherency on the every-cycle instance
    wr(0, 32'hFFFF_FFFE);
    wr(1, 32'd0);
    rd(0);
    check("t4_lo", bus_b.rdata_o, 32'hFFFF_FFFF);
    idle();
    idle();
    rd(1);
    check("t4_hi", bus_b.rdata_o, 32'd0);

    // T5 write/tick collision and byte lanes
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_pre[0] == 3) found = 1'b1;
      else idle();
    end
    if (!found) check("t5_timeout", 1'b0, 1'b1);
    wr(0, 32'h1234);
    repeat (7) idle();
    rd(0);
    check("t5_collide", bus_a.rdata_o, 32'h1235);
    wr(2, 32'h1122_3344);
    step(1'b1, 1'b1, BASE + 32'd8, 32'hFFFF_FFAB, 4'b0001);
    rd(2);
    check("t5_byte", bus_a.rdata_o, 32'h1122_33AB);

    // T6 back-to-back reads, off-map and unmapped offset
    for (int i = 0; i < 4; i++) begin
      rd(i);
      check("t6_b2b_ack", bus_a.ack_o, 1'b1);
    end
    step(1'b1, 1'b0, 32'h0000_1000, 32'd0, 4'h0);
    check("t6_offmap", bus_a.ack_o, 1'b0);
    step(1'b1, 1'b1, BASE | 32'h8000_0000, 32'd0, 4'hF);
    check("t6_offmap_w", bus_a.ack_o, 1'b0);
    rd(7);
    check("t6_off7_ack", bus_a.ack_o, 1'b1);
    check("t6_off7_data", bus_a.rdata_o, 32'd0);

    // randomized traffic against the reference
    for (int i = 0; i < 1500; i++) begin
      bit req, we;
      logic [31:0] addr, wd;
      int off;
      req = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 9) < 4);
      off = $urandom_range(0, 7);
      addr = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      wd = $urandom;
      if (off == 1 || off == 3) wd = 32'($urandom_range(0, 2));
      if (off == 0 || off == 2) wd = 32'($urandom_range(0, 300));
      if (off == 4 && $urandom_range(0, 3) != 0) wd = 32'd1;
      step(req, we, addr, wd, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
